// File: rtl/wb_pic.sv
// wb_pic: Wishbone-attached priority interrupt controller.
// NCH maskable edge-triggered channels (channel 0 highest priority) plus
// one NMI. Inputs are asynchronous and active-low; each passes through a
// synchroniser and a history flop so that only falling edges are counted.
//
// Handshakes:
//   Wishbone: a request is cyc & stb; wb_ack_o rises one cycle later for
//   exactly one cycle, register writes commit on the ack cycle, and
//   wb_dat_o carries read data only while wb_ack_o is high (zero otherwise).
//   inta_i / nmia_i: level signals from the CPU; only their rising edges act.
//   vec_o presents NMI_VEC while nmia_i is high, otherwise the vector
//   latched by the most recent interrupt acknowledge.
module wb_pic #(
    parameter int         NCH         = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] VEC_BASE    = 8'h0C,
    parameter logic [7:0] NMI_VEC     = 8'h02
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] irq_n_i,
    input  logic           nmi_n_i,
    input  logic [1:0]     wb_adr_i,
    input  logic [15:0]    wb_dat_i,
    output logic [15:0]    wb_dat_o,
    input  logic [1:0]     wb_sel_i,
    input  logic           wb_we_i,
    input  logic           wb_stb_i,
    input  logic           wb_cyc_i,
    output logic           wb_ack_o,
    output logic           intr_o,
    input  logic           inta_i,
    output logic           nmi_o,
    input  logic           nmia_i,
    output logic [7:0]     vec_o
);

    // Bit NCH of the source vector is the NMI; bits below are the channels.
    localparam int         NSRC        = NCH + 1;
    localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
    logic [NSRC-1:0]                  hist_q;
    logic [2:0]                       settle_q;
    logic                             armed;
    logic [NSRC-1:0]                  fall;

    logic [NCH-1:0] pend_q, insv_q, mask_q;
    logic [NCH-1:0] pend_d, insv_d, mask_d;
    logic [NCH-1:0] pend_clr, insv_clr;
    logic [NCH-1:0] live, cand_oh, eoi_bit, wr_bits;
    logic           cand_v, insv_blk;
    logic [2:0]     cand_idx;
    logic [7:0]     cand_vec;
    logic [7:0]     vec_q;
    logic           inta_q, nmia_q, int_ack, nmi_ack;
    logic           bus_req, wr_en;
    logic [15:0]    rd_data;
    logic           unused_bits;

    assign unused_bits = ^{wb_dat_i[15:NCH], wb_sel_i[1]};

    // Synchroniser chain and history flop; all reset to the inactive (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q[0] <= {nmi_n_i, irq_n_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // After reset, hold off edge detection until the history flop has
    // re-sampled a real input value, so a line held low through reset is
    // never mistaken for a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst)         settle_q <= '0;
        else if (!armed) settle_q <= settle_q + 3'd1;
    end

    assign armed = (settle_q == SETTLE_DONE);
    assign fall  = armed ? (hist_q & ~sync_q[SYNC_STAGES-1]) : '0;

    // Candidate selection: lowest unmasked pending channel, and whether an
    // in-service channel of equal or higher priority blocks it.
    always_comb begin
        live     = pend_q & ~mask_q;
        cand_v   = 1'b0;
        cand_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (live[i]) begin
                cand_v   = 1'b1;
                cand_idx = 3'(i);
            end
        end
        insv_blk = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (insv_q[i] && (3'(i) <= cand_idx)) insv_blk = 1'b1;
        end
    end

    assign cand_oh  = cand_v ? (NCH'(1) << cand_idx) : '0;
    assign cand_vec = VEC_BASE + {5'd0, cand_idx};
    // Isolates the lowest set INSV bit (highest priority in service).
    assign eoi_bit  = insv_q & (~insv_q + NCH'(1));

    assign bus_req = wb_cyc_i & wb_stb_i;
    assign wr_en   = wb_ack_o & bus_req & wb_we_i & wb_sel_i[0];
    assign wr_bits = wb_dat_i[NCH-1:0];
    assign int_ack = inta_i & ~inta_q & ~nmia_i;
    assign nmi_ack = nmia_i & ~nmia_q;

    // Register next-state: clears from bus writes and acknowledge, then
    // new edges OR'd in last so a same-cycle set beats any clear.
    always_comb begin
        pend_clr = '0;
        insv_clr = '0;
        mask_d   = mask_q;
        if (wr_en) begin
            case (wb_adr_i)
                2'd0:    mask_d   = wr_bits;
                2'd1:    pend_clr = wr_bits;
                2'd2:    insv_clr = wr_bits;
                default: insv_clr = eoi_bit;
            endcase
        end
        if (int_ack) pend_clr = pend_clr | cand_oh;
        pend_d = (pend_q & ~pend_clr) | fall[NCH-1:0];
        insv_d = (insv_q & ~insv_clr) | (int_ack ? cand_oh : '0);
    end

    // Channel state registers and the registered interrupt request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            insv_q <= '0;
            mask_q <= '0;
            intr_o <= 1'b0;
        end else begin
            pend_q <= pend_d;
            insv_q <= insv_d;
            mask_q <= mask_d;
            intr_o <= cand_v & ~insv_blk;
        end
    end

    // Acknowledge edge detection, NMI request flag and latched vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            inta_q <= 1'b0;
            nmia_q <= 1'b0;
            nmi_o  <= 1'b0;
            vec_q  <= 8'h00;
        end else begin
            inta_q <= inta_i;
            nmia_q <= nmia_i;
            if (fall[NCH])    nmi_o <= 1'b1;
            else if (nmi_ack) nmi_o <= 1'b0;
            if (int_ack)      vec_q <= cand_v ? cand_vec : (VEC_BASE + 8'd7);
        end
    end

    assign vec_o = nmia_i ? NMI_VEC : vec_q;

    // Single-cycle registered bus acknowledge; a reset drops any cycle in flight.
    always_ff @(posedge clk) begin
        if (rst) wb_ack_o <= 1'b0;
        else     wb_ack_o <= bus_req & ~wb_ack_o;
    end

    // Read data mux; upper byte and unused channel bits read as zero.
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            2'd0:    rd_data[NCH-1:0] = mask_q;
            2'd1:    rd_data[NCH-1:0] = pend_q;
            2'd2:    rd_data[NCH-1:0] = insv_q;
            default: rd_data[7:0]     = cand_v ? cand_vec : 8'hFF;
        endcase
    end

    assign wb_dat_o = wb_ack_o ? rd_data : 16'h0000;

endmodule

// File: doc/wb_pic.md
WB_PIC -- requirements
Module: wb_pic

Interface
REQ-001 Parameter NCH, default 4, number of maskable interrupt channels (1..8).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth per input (2..4).
REQ-003 Parameter VEC_BASE, default 8'h0C, vector number of channel 0; channel n vector = VEC_BASE+n, modulo 256.
REQ-004 Parameter NMI_VEC, default 8'h02, vector presented during NMI acknowledge.
REQ-005 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 irq_n_i  in  NCH  asynchronous active-low interrupt sources (tube p_irq_b on ch0).
REQ-008 nmi_n_i  in  1  asynchronous active-low NMI source.
REQ-009 wb_adr_i  in  2  register select (word address bits 2:1); wb_dat_i in 16; wb_dat_o out 16; wb_sel_i in 2; wb_we_i, wb_stb_i, wb_cyc_i in 1; wb_ack_o out 1.
REQ-010 intr_o  out  1  interrupt request to CPU; inta_i  in  1  CPU interrupt acknowledge (level, held for the ack bus cycle).
REQ-011 nmi_o  out  1  NMI request; nmia_i  in  1  NMI acknowledge.
REQ-012 vec_o  out  8  vector to be muxed onto CPU read data during acknowledge.

Function
REQ-013 Each input SHALL pass through SYNC_STAGES flops, then one history flop; a synchronised falling edge of irq_n_i[n] SHALL set PEND[n] one cycle later (latency SYNC_STAGES+1 clocks from input edge).
REQ-014 Level-low without a new edge SHALL NOT re-set PEND; edges are counted once, further edges while PEND[n]=1 are merged.
REQ-015 Priority: channel 0 highest; candidate = lowest n with PEND[n] & ~MASK[n].
REQ-016 intr_o SHALL be registered, high when a candidate exists and no INSV bit of equal or higher priority is set.
REQ-017 On rising edge of inta_i (inta_i & ~inta_q): latch candidate into vec_o, clear its PEND, set its INSV, drop intr_o next cycle; vec_o SHALL hold until next acknowledge.
REQ-018 inta_i rising with no candidate (spurious): vec_o = VEC_BASE+7, PEND/INSV unchanged.
REQ-019 NMI edge SHALL set nmi_o; rising edge of nmia_i SHALL clear it; vec_o SHALL read NMI_VEC while nmia_i high, NMI takes precedence over inta_i.
REQ-020 Same-cycle new edge and clear (ack, W1C, or nmia) on one bit: set SHALL win.
REQ-021 Registers: adr 0 MASK (R/W, 1=masked), adr 1 PEND (R, write-1-to-clear), adr 2 INSV (R, write-1-to-clear), adr 3 EOI (write any value clears highest-priority INSV bit; read returns {8'h00, candidate vector or 8'hFF if none}).
REQ-022 Writes SHALL apply only bits [NCH-1:0] and only when wb_sel_i[0]=1; upper byte and unused bits read 0.
REQ-023 wb_ack_o SHALL be registered: asserted one cycle after wb_cyc_i & wb_stb_i & ~wb_ack_o, for exactly one cycle; register update occurs on the ack cycle; wb_dat_o valid while wb_ack_o high.
REQ-024 EOI with INSV=0 SHALL have no effect; MASK changes SHALL affect intr_o on the next cycle.

Reset
REQ-025 rst SHALL clear PEND, INSV, MASK (all unmasked), nmi_o, intr_o, wb_ack_o, all synchroniser/history flops to inactive, vec_o to 8'h00.
REQ-026 An input held low through reset deassertion SHALL NOT generate an edge (history flops reset to the deasserted level and re-sample); a bus cycle in flight at reset is dropped without ack.

Verification
REQ-027 irq_n_i[0] falls, default params -> PEND=0001 after 3 clocks, intr_o next cycle; inta_i pulse -> vec_o=8'h0C, INSV=0001, intr_o low.
REQ-028 ch2 and ch1 fall same cycle -> first inta gives 8'h0D; intr_o stays low until EOI write, then second inta gives 8'h0E.
REQ-029 MASK=0001 written, ch0 edge -> PEND=0001, intr_o stays 0; write MASK=0 -> intr_o asserts next cycle.
REQ-030 nmi_n_i falls while ch0 pending, nmia_i and inta_i both high -> vec_o=8'h02, nmi_o clears, PEND[0] unchanged.
REQ-031 New ch1 edge coincident with W1C of PEND[1] -> PEND[1]=1; EOI read with nothing pending -> 16'h00FF.
REQ-032 rst asserted mid bus cycle with irq_n_i[0] low -> no ack, all outputs zero, no PEND set after rst release.
